// File: rtl/xs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : xs_pkg                                                 |
// | Description : Shared widths, scheduler state encoding and the        |
// |               XOR-shift step function used by xs_round_sched.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package xs_pkg;

  // Default operand/result width and round-count field width
  localparam int XS_W  = 8;
  localparam int XS_RW = 3;

  // Scheduler states; 2-bit encoding leaves one unused code
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } xs_state_e;

  // One XOR-shift step: XOR with b, then shift left by one if the
  // pre-XOR MSB of a was set (zero fill on the right).
  function automatic logic [XS_W-1:0] xs_step(input logic [XS_W-1:0] a,
                                              input logic [XS_W-1:0] b);
    logic [XS_W-1:0] x;
    x = a ^ b;
    xs_step = a[XS_W-1] ? {x[XS_W-2:0], 1'b0} : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xs_step_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xs_step_unit                                           |
// | Description : Combinational XOR-shift step datapath. Single shared   |
// |               instance owned by the round scheduler.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module xs_step_unit
  import xs_pkg::*;
#(
  parameter int W = XS_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_c
);

  generate
    if (W == XS_W) begin : g_pkg_width
      // Package function is sized for the default width
      assign o_c = xs_step(i_a, i_b);
    end else begin : g_any_width
      // Same rule spelled out for a non-default width
      logic [W-1:0] w_x;
      assign w_x = i_a ^ i_b;
      assign o_c = i_a[W-1] ? {w_x[W-2:0], 1'b0} : w_x;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/xs_round_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xs_round_sched                                         |
// | Description : Round-robin scheduler sharing one XOR-shift step unit  |
// |               between two requesters. Each job iterates the step R   |
// |               times and returns a tagged result.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module xs_round_sched
  import xs_pkg::*;
#(
  parameter int W  = XS_W,
  parameter int RW = XS_RW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*W-1:0]  req_a,
  input  logic [2*W-1:0]  req_b,
  input  logic [2*RW-1:0] req_r,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic            res_id,
  output logic            busy
);

  xs_state_e       r_state;
  xs_state_e       w_state_nxt;

  logic            r_last_grant;
  logic            w_pref;
  logic            w_grant;
  logic            w_grant_vld;
  logic            w_accept;

  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;
  logic [RW-1:0]   w_r_sel;

  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_b;
  logic [RW-1:0]   r_cnt;
  logic            r_id;
  logic [W-1:0]    w_step;

  logic            r_res_valid;
  logic [W-1:0]    r_res_data;
  logic            r_res_id;

  // Round-robin winner: the requester after the last grant has priority
  always_comb begin
    w_pref      = ~r_last_grant;
    w_grant     = w_pref;
    w_grant_vld = 1'b0;
    if (req_valid[w_pref]) begin
      w_grant     = w_pref;
      w_grant_vld = 1'b1;
    end else if (req_valid[~w_pref]) begin
      w_grant     = ~w_pref;
      w_grant_vld = 1'b1;
    end
  end

  // Ready is offered only to the winner, only while idle and out of reset
  assign req_ready = ((r_state == ST_IDLE) && rst_n && w_grant_vld) ?
                     {w_grant, ~w_grant} : 2'b00;
  assign w_accept  = (r_state == ST_IDLE) && w_grant_vld;

  // Operand mux for the granted requester
  assign w_a_sel = w_grant ? req_a[2*W-1:W]   : req_a[W-1:0];
  assign w_b_sel = w_grant ? req_b[2*W-1:W]   : req_b[W-1:0];
  assign w_r_sel = w_grant ? req_r[2*RW-1:RW] : req_r[RW-1:0];

  // The single shared step datapath
  xs_step_unit #(
    .W (W)
  ) u_step (
    .i_a (r_acc),
    .i_b (r_b),
    .o_c (w_step)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: zero-round jobs skip RUN entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_r_sel != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (r_cnt == RW'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_res_valid && res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Job registers: capture on accept, iterate the step while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc        <= w_a_sel;
            r_b          <= w_b_sel;
            r_cnt        <= w_r_sel;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
          end
        end
        ST_RUN: begin
          r_acc <= w_step;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - RW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Response register: loaded on the first DONE cycle, held until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= 1'b0;
    end else if (r_state == ST_DONE) begin
      if (!r_res_valid) begin
        r_res_valid <= 1'b1;
        r_res_data  <= r_acc;
        r_res_id    <= r_id;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
